// File: rtl/ppu_pkg.sv
// Shared PPU definitions: DMA engine state encoding and CPU register select codes.
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [1:0] SEL_OAMADDR = 2'd0;
    localparam logic [1:0] SEL_OAMDATA = 2'd1;
    localparam logic [1:0] SEL_DMA     = 2'd2;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM register port and 256-byte sprite DMA engine. It halts the CPU, copies
// page XX00..XXFF into sprite RAM starting at OAMADDR (with wrap), and also
// handles single-byte OAMDATA writes while idle.
module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter logic ALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic [1:0]  reg_sel,
    input  logic [7:0]  reg_wdata,
    input  logic        cpu_odd_cycle,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_halt,
    output logic        spram_we,
    output logic [7:0]  spram_waddr,
    output logic [7:0]  spram_wdata,
    output logic [7:0]  oam_addr,
    output logic        busy
);

    dma_state_t state;
    logic [7:0] page;
    logic [8:0] count;
    logic [8:0] count_inc;

    // Single-byte OAMDATA write, presented the cycle after the CPU strobe.
    logic       pio_we;
    logic [7:0] pio_addr;
    logic [7:0] pio_data;

    assign count_inc = count + 9'd1;
    assign busy      = (state != ST_IDLE);

    // In WRITE the byte read last cycle goes straight to the RAM port; otherwise the
    // registered OAMDATA write (if any) owns it.
    always_comb begin
        spram_we    = pio_we;
        spram_waddr = pio_addr;
        spram_wdata = pio_data;
        if (state == ST_WRITE) begin
            spram_we    = 1'b1;
            spram_waddr = oam_addr;
            spram_wdata = mem_rdata;
        end
    end

    // DMA sequencer plus CPU register decode; register writes are only honoured in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            oam_addr <= 8'h00;
            page     <= 8'h00;
            count    <= 9'd0;
            cpu_halt <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= 16'h0000;
            pio_we   <= 1'b0;
            pio_addr <= 8'h00;
            pio_data <= 8'h00;
        end else begin
            mem_rd <= 1'b0;
            pio_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reg_wr) begin
                        case (reg_sel)
                            SEL_OAMADDR: oam_addr <= reg_wdata;
                            SEL_OAMDATA: begin
                                pio_we   <= 1'b1;
                                pio_addr <= oam_addr;
                                pio_data <= reg_wdata;
                                oam_addr <= oam_addr + 8'd1;
                            end
                            SEL_DMA: begin
                                page     <= reg_wdata;
                                count    <= 9'd0;
                                cpu_halt <= 1'b1;
                                state    <= ST_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_HALT: begin
                    if ((ALIGN_EN != 1'b0) && cpu_odd_cycle) begin
                        state <= ST_ALIGN;
                    end else begin
                        state    <= ST_READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, count[7:0]};
                    end
                end
                ST_ALIGN: begin
                    state    <= ST_READ;
                    mem_rd   <= 1'b1;
                    mem_addr <= {page, count[7:0]};
                end
                ST_READ: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    oam_addr <= oam_addr + 8'd1;
                    count    <= count_inc;
                    if (count_inc == 9'd256) begin
                        state    <= ST_IDLE;
                        cpu_halt <= 1'b0;
                    end else begin
                        state    <= ST_READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, count_inc[7:0]};
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Self-checking bench for ppu_oam_dma: queue-based model of expected bus reads
// and sprite RAM writes, one negedge compare process, directed scenarios.
module tb_ppu_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_sel = 2'd0;
    logic [7:0]  reg_wdata = 8'h00;
    logic        cpu_odd_cycle = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cpu_halt;
    logic        spram_we;
    logic [7:0]  spram_waddr;
    logic [7:0]  spram_wdata;
    logic [7:0]  oam_addr;
    logic        busy;

    ppu_oam_dma dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
        .cpu_odd_cycle(cpu_odd_cycle), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .cpu_halt(cpu_halt), .spram_we(spram_we),
        .spram_waddr(spram_waddr), .spram_wdata(spram_wdata), .oam_addr(oam_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // CPU bus memory: byte at A is A[7:0]^0x5A, returned the cycle after the read.
    always @(posedge clk) mem_rdata <= mem_rd ? (mem_addr[7:0] ^ 8'h5A) : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [7:0]  model_oam = 8'h00;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];          // {addr, data}
    logic [7:0]  bench_spram [256];
    logic [15:0] rd_log [256];
    logic [7:0]  wr_log [256];
    int          rd_idx = 0;
    int          wr_idx = 0;
    int          halt_cnt = 0;
    int          halt_len = 0;
    int          first_rd_at = 0;
    bit          seen_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every cycle, bus activity and RAM writes are checked against the model.
    always @(negedge clk) begin
        logic [15:0] e;
        if (spram_we) begin
            if (exp_wr.size() == 0) chk("unexpected spram_we", {spram_waddr, spram_wdata}, 32'hDEAD);
            else begin
                e = exp_wr.pop_front();
                chk("spram write addr/data", {spram_waddr, spram_wdata}, e);
            end
            bench_spram[spram_waddr] = spram_wdata;
            if (wr_idx < 256) wr_log[wr_idx] = spram_waddr;
            wr_idx++;
        end
        if (mem_rd) begin
            if (exp_rd.size() == 0) chk("unexpected mem_rd", mem_addr, 32'hDEAD);
            else begin
                e = exp_rd.pop_front();
                chk("mem_addr", mem_addr, e);
            end
            if (rd_idx < 256) rd_log[rd_idx] = mem_addr;
            rd_idx++;
        end
        if (cpu_halt !== busy) chk("cpu_halt==busy", cpu_halt, busy);
        if (rst && !busy && oam_addr !== model_oam) chk("idle oam_addr", oam_addr, model_oam);
        if (cpu_halt) begin
            halt_cnt++;
            if (mem_rd && !seen_rd) begin first_rd_at = halt_cnt; seen_rd = 1; end
        end else if (halt_cnt != 0) begin
            halt_len = halt_cnt; halt_cnt = 0; seen_rd = 0;
        end
    end

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
        @(posedge clk); #1;
        reg_wr = 1'b1; reg_sel = sel; reg_wdata = d;
        @(posedge clk); #1;
        reg_wr = 1'b0;
    endtask

    task automatic set_oamaddr(input logic [7:0] a);
        reg_write(2'd0, a);
        model_oam = a;
    endtask

    task automatic write_oamdata(input logic [7:0] d);
        reg_write(2'd1, d);
        exp_wr.push_back({model_oam, d});
        model_oam = model_oam + 8'd1;
    endtask

    task automatic start_dma(input logic [7:0] pg);
        rd_idx = 0; wr_idx = 0;
        reg_write(2'd2, pg);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            exp_rd.push_back({pg, lo});
            exp_wr.push_back({8'(model_oam + lo), 8'(lo ^ 8'h5A)});
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk); #1;
            if (!busy) done = 1;
        end
        if (!done) chk({name, " timeout"}, 0, 1);
    endtask

    task automatic finish_dma(input string name, input int exp_len, input int exp_first);
        wait_idle(name);
        @(negedge clk); #1;
        chk({name, " halt cycles"}, halt_len, exp_len);
        chk({name, " first mem_rd cycle"}, first_rd_at, exp_first);
        chk({name, " reads left"}, exp_rd.size(), 0);
        chk({name, " writes left"}, exp_wr.size(), 0);
        chk({name, " write count"}, wr_idx, 256);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst cpu_halt", cpu_halt, 0);
        chk("rst mem_rd", mem_rd, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst spram_we", spram_we, 0);
        chk("rst spram_waddr/wdata", {spram_waddr, spram_wdata}, 0);
        chk("rst oam_addr", oam_addr, 0);
        chk("rst busy", busy, 0);
        @(posedge clk); #1; rst = 1'b1;

        // Plain DMA, page 0x02, even cycle
        set_oamaddr(8'h00);
        start_dma(8'h02);
        finish_dma("dma02", 513, 2);
        chk("dma02 spram[00]", bench_spram[8'h00], 8'h5A);
        chk("dma02 spram[80]", bench_spram[8'h80], 8'hDA);
        chk("dma02 spram[FF]", bench_spram[8'hFF], 8'hA5);
        chk("dma02 src[0]", rd_log[0], 16'h0200);
        chk("dma02 oam_addr end", oam_addr, 8'h00);

        // Odd-cycle start adds one alignment cycle
        cpu_odd_cycle = 1'b1;
        start_dma(8'h03);
        finish_dma("dma03 odd", 514, 3);
        cpu_odd_cycle = 1'b0;
        chk("dma03 src[255]", rd_log[255], 16'h03FF);

        // Wrapping DMA from OAMADDR 0xF0
        set_oamaddr(8'hF0);
        start_dma(8'h07);
        finish_dma("dma07 wrap", 513, 2);
        chk("wrap first waddr", wr_log[0], 8'hF0);
        chk("wrap first src", rd_log[0], 16'h0700);
        chk("wrap write16 waddr", wr_log[16], 8'h00);
        chk("wrap write16 src", rd_log[16], 16'h0710);
        chk("wrap oam_addr end", oam_addr, 8'hF0);

        // Single-byte OAMDATA writes
        set_oamaddr(8'h10);
        write_oamdata(8'hAA);
        write_oamdata(8'hBB);
        @(negedge clk); #1;
        chk("oamdata spram[10]", bench_spram[8'h10], 8'hAA);
        chk("oamdata spram[11]", bench_spram[8'h11], 8'hBB);
        chk("oamdata oam_addr", oam_addr, 8'h12);

        // Register writes during DMA are ignored
        set_oamaddr(8'h00);
        start_dma(8'h01);
        repeat (20) @(posedge clk);
        reg_write(2'd1, 8'h99);
        reg_write(2'd0, 8'h44);
        reg_write(2'd2, 8'h05);
        chk("busy during ignored writes", busy, 1);
        finish_dma("dma01 ignore", 513, 2);
        chk("ignore oam_addr end", oam_addr, 8'h00);

        // Reset in the middle of a transfer
        start_dma(8'h06);
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 1000 && !hit; c++) begin
                @(negedge clk); #1;
                if (wr_idx >= 100) hit = 1;
            end
            if (!hit) chk("reset test reach transfer 100", 0, 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete(); exp_wr.delete(); model_oam = 8'h00;
        #1;
        chk("abort cpu_halt", cpu_halt, 0);
        chk("abort oam_addr", oam_addr, 0);
        chk("abort busy", busy, 0);
        chk("abort spram_we", spram_we, 0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("after abort busy", busy, 0);
        start_dma(8'h04);
        finish_dma("dma04 after reset", 513, 2);
        chk("dma04 src[0]", rd_log[0], 16'h0400);
        chk("dma04 oam_addr end", oam_addr, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
PPU_OAM_DMA -- requirements
Module: ppu_oam_dma

Interface
REQ-001 SHALL have parameter ALIGN_EN, default 1; 1 inserts one alignment cycle when the DMA starts on an odd CPU cycle.
REQ-002 SHALL have clk, input, 1, clock; reset rst, asynchronous, active-low; clock clk.
REQ-003 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have reg_wr, input, 1, one-cycle CPU register write strobe.
REQ-005 SHALL have reg_sel, input, 2, register select: 0=OAMADDR, 1=OAMDATA, 2=DMA, 3=ignored.
REQ-006 SHALL have reg_wdata, input, 8, CPU write data.
REQ-007 SHALL have cpu_odd_cycle, input, 1, high on odd CPU cycles.
REQ-008 SHALL have mem_addr, output, 16, CPU-bus read address.
REQ-009 SHALL have mem_rd, output, 1, CPU-bus read strobe.
REQ-010 SHALL have mem_rdata, input, 8, read data, valid the cycle after mem_rd.
REQ-011 SHALL have cpu_halt, output, 1, stalls the CPU core.
REQ-012 SHALL have spram_we, output, 1, sprite RAM write enable.
REQ-013 SHALL have spram_waddr, output, 8, sprite RAM write address.
REQ-014 SHALL have spram_wdata, output, 8, sprite RAM write data.
REQ-015 SHALL have oam_addr, output, 8, current OAMADDR; drives the sprite loader's start address.
REQ-016 SHALL have busy, output, 1, high in every state other than IDLE.

Function
REQ-017 SHALL use the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-018 SHALL respond to reg_wr with reg_sel=0 in IDLE by setting oam_addr=reg_wdata on the next edge.
REQ-019 SHALL respond to reg_wr with reg_sel=1 in IDLE by driving, in the next cycle, spram_we=1, spram_waddr=old oam_addr and spram_wdata=reg_wdata; oam_addr then increments mod 256.
REQ-020 SHALL respond to reg_wr with reg_sel=2 in IDLE by latching page=reg_wdata, clearing the 9-bit transfer count and entering HALT.
REQ-021 SHALL hold cpu_halt=1 in HALT, ALIGN, READ and WRITE; cpu_halt SHALL be registered.
REQ-022 SHALL move from HALT to ALIGN when ALIGN_EN=1 and cpu_odd_cycle=1 is sampled in HALT; otherwise HALT SHALL move to READ.
REQ-023 SHALL move from ALIGN to READ after exactly one cycle.
REQ-024 SHALL drive mem_rd=1 and mem_addr={page, count[7:0]} in READ, then go to WRITE.
REQ-025 SHALL drive spram_we=1, spram_waddr=oam_addr and spram_wdata=mem_rdata in WRITE, increment oam_addr mod 256 and increment count.
REQ-026 SHALL, in WRITE, go to IDLE when the incremented count equals 256; otherwise it SHALL go to READ.
REQ-027 SHALL keep cpu_halt high for 513 cycles without ALIGN and 514 cycles with ALIGN.
REQ-028 SHALL leave oam_addr equal to its value at DMA start once the DMA ends, because of the 256-step wrap.
REQ-029 SHALL treat every reg_wr during busy=1 as a no-op: no oam_addr change, no spram write, no restart.
REQ-030 SHALL perform a wrapping DMA when oam_addr≠0: writes go to oam_addr..oam_addr+255 mod 256.
REQ-031 SHALL hold mem_rd=0 and spram_we=0 in IDLE unless REQ-019 applies, and in HALT and ALIGN.
REQ-032 SHALL accept a new DMA in the first IDLE cycle after completion.

Reset
REQ-033 SHALL, while rst=0, force state=IDLE, oam_addr=0, page=0, count=0, cpu_halt=0, mem_rd=0, mem_addr=0, spram_we=0, spram_waddr=0, spram_wdata=0 and busy=0.
REQ-034 SHALL abort a DMA in progress on reset assertion with no further spram writes and cpu_halt deasserted; after reset release it SHALL be idle.

Structure
REQ-035 SHALL take the state enum and the reg_sel codes (OAMADDR, OAMDATA, DMA) from the shared PPU package, ppu_pkg.
REQ-036 SHALL be a single flat module with no sub-module; the sprite RAM is external and dual-port, with this block on the write port and the sprite loader on the read port.

Verification
REQ-037 SHALL cover: OAMADDR=0x00; DMA page 0x02 on an even cycle; mem_rdata=addr[7:0]^0x5A -> 256 writes, spram[i]=i^0x5A, cpu_halt high 513 cycles, oam_addr=0x00 at end.
REQ-038 SHALL cover: DMA page 0x03 started with cpu_odd_cycle=1 -> first mem_rd one cycle later than in REQ-037, cpu_halt high 514 cycles.
REQ-039 SHALL cover: OAMADDR=0xF0, DMA page 0x07 -> first write to address 0xF0 with source 0x0700; write 16 goes to 0x00 with source 0x0710; final oam_addr=0xF0.
REQ-040 SHALL cover: OAMADDR=0x10, then OAMDATA 0xAA, 0xBB -> spram[0x10]=0xAA, spram[0x11]=0xBB, oam_addr=0x12.
REQ-041 SHALL cover: during a DMA, OAMDATA 0x99, OAMADDR 0x44 and DMA 0x05 writes -> all ignored, original transfer completes unchanged.
REQ-042 SHALL cover: rst low at transfer 100 -> cpu_halt=0, oam_addr=0, no spram_we afterwards; a following DMA runs normally.
